round_sequencer: RTL and testbench

Round controller for the memory-game datapath: after a one-hot difficulty select it generates a random LED pattern, plays it on the 8 LEDs, then scores the player's 8-button replay step by step across a fixed number of rounds. It sits between the debounced button/DIP front end and the LED/7-segment display logic inside GameManager. Display logic reads its round, score and phase outputs.

---
 rtl/round_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_round_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Memory-game round controller: pattern generation, LED playback,
// replay scoring and round/score bookkeeping.
module round_sequencer #(
   parameter int TICK_DIV       = 1000,
   parameter int STEP_ON_TICKS  = 4,
   parameter int STEP_OFF_TICKS = 2,
   parameter int TIMEOUT_TICKS  = 50,
   parameter int ROUNDS         = 10,
   parameter int LEN_1          = 4,
   parameter int LEN_2          = 12,
   parameter int LEN_3          = 16
) (
   input  logic       clk_2,
   input  logic       dip_rst,
   input  logic [2:0] diff_sel,
   input  logic [7:0] btn_pulse,
   output logic [7:0] led,
   output logic [3:0] round,
   output logic [7:0] score,
   output logic [2:0] phase,
   output logic       hit_pulse,
   output logic       miss_pulse,
   output logic       game_over
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] GEN     = 3'd1;
   localparam logic [2:0] SHOW    = 3'd2;
   localparam logic [2:0] INPUT   = 3'd3;
   localparam logic [2:0] RND_END = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);
   localparam logic [15:0] ON_MAX  = 16'(STEP_ON_TICKS - 1);
   localparam logic [15:0] OFF_MAX = 16'(STEP_OFF_TICKS - 1);
   localparam logic [15:0] TO_MAX  = 16'(TIMEOUT_TICKS - 1);
   localparam logic [3:0]  RND_MAX = 4'(ROUNDS);

   logic [15:0] lfsr;
   logic [15:0] pre;
   logic [15:0] tcnt;
   logic [4:0]  len;
   logic [4:0]  idx;
   logic        on;
   logic [2:0]  pat [16];

   logic       tick;
   logic       last;
   logic       fb;
   logic [2:0] cur;
   logic [2:0] btn_idx;
   logic       hit;
   logic       press;

   assign tick  = (pre == PRE_MAX);
   assign last  = (idx == len - 5'd1);
   assign fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign cur   = pat[idx[3:0]];
   assign press = (btn_pulse != 8'd0);
   assign hit   = $onehot(btn_pulse) && (btn_idx == cur);

   always_comb begin
      btn_idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (btn_pulse[i]) btn_idx = 3'(i);
   end

   // idx doubles as the write pointer while generating
   always_ff @(posedge clk_2) begin
      if (!dip_rst && phase == GEN)
         pat[idx[3:0]] <= lfsr[2:0];
   end

   always_ff @(posedge clk_2) begin
      if (dip_rst) begin
         lfsr       <= 16'hACE1;
         pre        <= 16'd0;
         tcnt       <= 16'd0;
         len        <= 5'd0;
         idx        <= 5'd0;
         on         <= 1'b0;
         led        <= 8'd0;
         round      <= 4'd0;
         score      <= 8'd0;
         phase      <= IDLE;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         lfsr       <= {lfsr[14:0], fb};
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         case (phase)
            IDLE: begin
               led <= 8'd0;
               if ($onehot(diff_sel)) begin
                  phase <= GEN;
                  idx   <= 5'd0;
                  unique case (1'b1)
                     diff_sel[0]: len <= 5'(LEN_1);
                     diff_sel[1]: len <= 5'(LEN_2);
                     diff_sel[2]: len <= 5'(LEN_3);
                  endcase
               end
            end
            GEN: begin
               led <= 8'd0;
               if (last) begin
                  phase <= SHOW;
                  idx   <= 5'd0;
                  pre   <= 16'd0;
                  tcnt  <= 16'd0;
                  on    <= 1'b1;
               end else begin
                  idx <= idx + 5'd1;
               end
            end
            SHOW: begin
               led <= on ? (8'd1 << cur) : 8'd0;
               pre <= tick ? 16'd0 : pre + 16'd1;
               if (tick) begin
                  if (on && tcnt == ON_MAX) begin
                     on   <= 1'b0;
                     tcnt <= 16'd0;
                  end else if (!on && tcnt == OFF_MAX) begin
                     on   <= 1'b1;
                     tcnt <= 16'd0;
                     if (last) begin
                        phase <= INPUT;
                        idx   <= 5'd0;
                     end else begin
                        idx <= idx + 5'd1;
                     end
                  end else begin
                     tcnt <= tcnt + 16'd1;
                  end
               end
            end
            INPUT: begin
               pre <= tick ? 16'd0 : pre + 16'd1;
               // a press wins over a coincident timeout tick
               if (press || (tick && tcnt == TO_MAX)) begin
                  pre  <= 16'd0;
                  tcnt <= 16'd0;
                  if (hit) begin
                     hit_pulse <= 1'b1;
                     led       <= btn_pulse;
                     if (score != 8'hFF) score <= score + 8'd1;
                  end else begin
                     miss_pulse <= 1'b1;
                     led        <= 8'hFF;
                  end
                  if (last) phase <= RND_END;
                  else      idx   <= idx + 5'd1;
               end else if (tick) begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            RND_END: begin
               round <= round + 4'd1;
               idx   <= 5'd0;
               if (round + 4'd1 == RND_MAX) begin
                  phase     <= DONE;
                  game_over <= 1'b1;
                  led       <= 8'hFF;
               end else begin
                  phase <= GEN;
                  led   <= 8'd0;
               end
            end
            DONE: begin
               game_over <= 1'b1;
               led       <= 8'hFF;
            end
            default: phase <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: decode table, show timing,
// scripted faults, randomized replays and mid-game resets.
module tb_round_sequencer;

   localparam int TD   = 4;
   localparam int ON   = 2;
   localparam int OFF  = 1;
   localparam int TO   = 5;
   localparam int RNDS = 2;

   logic       clk;
   logic       rst;
   logic [2:0] diff;
   logic [7:0] btn;
   logic [7:0] led;
   logic [3:0] round;
   logic [7:0] score;
   logic [2:0] phase;
   logic       hit_pulse;
   logic       miss_pulse;
   logic       game_over;

   round_sequencer #(
      .TICK_DIV(TD), .STEP_ON_TICKS(ON), .STEP_OFF_TICKS(OFF),
      .TIMEOUT_TICKS(TO), .ROUNDS(RNDS),
      .LEN_1(4), .LEN_2(3), .LEN_3(6)
   ) dut (
      .clk_2(clk), .dip_rst(rst), .diff_sel(diff),
      .btn_pulse(btn), .led(led), .round(round), .score(score),
      .phase(phase), .hit_pulse(hit_pulse),
      .miss_pulse(miss_pulse), .game_over(game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] sel;
      int         exp_phase;
      int         exp_len;
   } vec_t;

   int         tests = 0;
   int         fails = 0;
   logic [15:0] m_lfsr;
   logic [2:0] m_pat [16];
   int         m_len;
   int         m_round;
   int         m_score;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      // taps 16,14,13,11 (1-based) feed bit 0
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      m_lfsr = rst ? 16'hACE1 : lfsr_next(m_lfsr);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_led"}, led, 0);
      chk({tag, "_round"}, round, 0);
      chk({tag, "_score"}, score, 0);
      chk({tag, "_phase"}, phase, 0);
      chk({tag, "_over"}, game_over, 0);
      chk({tag, "_hit"}, hit_pulse, 0);
      chk({tag, "_miss"}, miss_pulse, 0);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      diff = 3'd0;
      btn  = 8'd0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic start_game(input logic [2:0] sel, input int n);
      m_len   = n;
      m_round = 0;
      m_score = 0;
      diff = sel;
      tick();
      diff = 3'd0;
      chk("gen_enter", phase, 1);
   endtask

   // mode 0: all correct, 1: scripted faults, 2: random
   task automatic play_round(input int mode);
      int         kind;
      int         p;
      int         q;
      logic [7:0] b;
      logic       exp_hit;
      for (int k = 0; k < m_len; k++) begin
         m_pat[k] = m_lfsr[2:0];
         tick();
      end
      chk("show_enter", phase, 2);
      for (int s = 0; s < m_len; s++) begin
         for (int c = 0; c < ON * TD; c++) begin
            tick();
            chk("show_on", led, 1 << m_pat[s]);
         end
         for (int c = 0; c < OFF * TD; c++) begin
            tick();
            chk("show_off", led, 0);
         end
      end
      chk("input_enter", phase, 3);
      for (int i = 0; i < m_len; i++) begin
         p = int'(m_pat[i]);
         if (mode == 0) kind = 0;
         else if (mode == 1) kind = (i < 3) ? i + 1 : 0;
         else kind = $urandom_range(0, 4);
         b = 8'd0;
         if (kind == 3) begin
            repeat (TO * TD - 1) tick();
            chk("timeout_early", miss_pulse, 0);
            tick();
         end else begin
            for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
               tick();
               if (g == 0) chk("pulse_clear", hit_pulse | miss_pulse, 0);
            end
            q = (p + 1 + int'($urandom_range(0, 6))) % 8;
            case (kind)
               0: b = 8'd1 << p;
               1: b = 8'd1 << q;
               2: b = (8'd1 << p) | (8'd1 << q);
               default: b = 8'($urandom_range(1, 255));
            endcase
            btn = b;
            tick();
            btn = 8'd0;
         end
         exp_hit = ($countones(b) == 1) && b[p];
         if (exp_hit && m_score < 255) m_score++;
         chk("hit", hit_pulse, int'(exp_hit));
         chk("miss", miss_pulse, int'(!exp_hit));
         chk("score", score, m_score);
         chk("fb_led", led, exp_hit ? int'(b) : 255);
         chk("step_phase", phase, (i == m_len - 1) ? 4 : 3);
      end
      tick();
      m_round++;
      chk("round", round, m_round);
      if (m_round == RNDS) begin
         chk("done_phase", phase, 5);
         chk("done_over", game_over, 1);
         chk("done_led", led, 255);
      end else begin
         chk("next_gen", phase, 1);
         chk("next_led", led, 0);
         chk("next_over", game_over, 0);
      end
   endtask

   initial begin
      vec_t vt [8];
      int   mx;
      int   n;
      int   lens [3];
      logic [2:0] sels [3];
      vt[0] = '{3'b000, 0, 0};
      vt[1] = '{3'b001, 1, 4};
      vt[2] = '{3'b010, 1, 3};
      vt[3] = '{3'b100, 1, 6};
      vt[4] = '{3'b011, 0, 0};
      vt[5] = '{3'b101, 0, 0};
      vt[6] = '{3'b110, 0, 0};
      vt[7] = '{3'b111, 0, 0};
      sels[0] = 3'b001; lens[0] = 4;
      sels[1] = 3'b010; lens[1] = 3;
      sels[2] = 3'b100; lens[2] = 6;
      m_lfsr = 16'd0;

      do_reset();
      check_reset_outs("reset");
      diff = 3'b011;
      mx = 0;
      repeat (100) begin
         tick();
         if (int'(phase) > mx) mx = int'(phase);
      end
      chk("multi_sel_idle", mx, 0);

      foreach (vt[v]) begin
         do_reset();
         diff = vt[v].sel;
         tick();
         diff = 3'd0;
         chk("sel_phase", phase, vt[v].exp_phase);
         if (vt[v].exp_phase == 1) begin
            n = 0;
            while (phase == 3'd1 && n < 20) begin
               tick();
               n++;
            end
            chk("gen_len", n, vt[v].exp_len);
         end
      end

      do_reset();
      start_game(3'b001, 4);
      play_round(0);
      chk("perfect_score", score, 4);
      play_round(1);
      chk("fault_score", score, 5);
      for (int c = 0; c < 30; c++) begin
         btn  = 8'($urandom);
         diff = 3'($urandom);
         tick();
         chk("hold_phase", phase, 5);
         chk("hold_led", led, 255);
         chk("hold_round", round, RNDS);
         chk("hold_score", score, 5);
         chk("hold_over", game_over, 1);
      end
      btn  = 8'd0;
      diff = 3'd0;

      do_reset();
      check_reset_outs("exit_done");
      start_game(3'b001, 4);
      play_round(0);
      play_round(0);
      chk("full_score", score, 2 * 4);
      chk("full_over", game_over, 1);

      for (int g = 0; g < 4; g++) begin
         n = $urandom_range(0, 2);
         do_reset();
         start_game(sels[n], lens[n]);
         play_round(2);
         play_round(2);
      end

      do_reset();
      start_game(3'b010, 3);
      repeat (3 + 6) tick();
      chk("mid_show_phase", phase, 2);
      rst = 1'b1;
      tick();
      check_reset_outs("rst_show");
      rst = 1'b0;
      start_game(3'b100, 6);
      play_round(0);
      for (int k = 0; k < m_len; k++) begin
         m_pat[k] = m_lfsr[2:0];
         tick();
      end
      repeat (m_len * (ON + OFF) * TD) tick();
      chk("mid_input_phase", phase, 3);
      btn = 8'd1 << m_pat[0];
      tick();
      btn = 8'd0;
      chk("mid_input_hit", hit_pulse, 1);
      rst = 1'b1;
      tick();
      check_reset_outs("rst_input");
      rst = 1'b0;
      start_game(3'b010, 3);
      play_round(0);
      play_round(0);
      chk("restart_score", score, 6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
